ddr4_modport: RTL and testbench

- Memory-side DDR4 command-bus monitor/decoder; sits between the controller's pin outputs and the memory model.
- Samples the control/address pins every clock and decodes them into a registered command code.
- Captures the row address on ACT and the column address on RD/WR, each with bank and bank group.
- Checks tRCD and tCCD_L/tCCD_S spacing and flags violations as one-cycle pulses with a saturating error count.

---
 rtl/ddr4_modport.sv | 164 ++++++++++++++++
 tb/tb_ddr4_modport.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_modport.sv
// DDR4 command-bus monitor: decodes pins into a registered command, captures addresses and
// flags tRCD/tCCD spacing. Define DDR4_READ_LATENCY_CHECK_EN to add the dq_valid/tcl_err check.
module ddr4_modport #(
    parameter int unsigned AWIDTH  = 18,
    parameter int unsigned BG_BITS = 2,
    parameter int unsigned B_BITS  = 2,
    parameter int unsigned TRCD    = 16,
    parameter int unsigned TCCD_L  = 6,
    parameter int unsigned TCCD_S  = 4,
    parameter int unsigned TCL     = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      cke,
    input  logic                      cs_n,
    input  logic                      act_n,
    input  logic [AWIDTH-1:0]         pin_A,
    input  logic [BG_BITS-1:0]        bg,
    input  logic [B_BITS-1:0]         b,
    output logic [3:0]                cmd,
    output logic [14:0]               row_addr,
    output logic [9:0]                col_addr,
    output logic [B_BITS+BG_BITS-1:0] act_bank,
    output logic [B_BITS+BG_BITS-1:0] col_bank,
    output logic                      trcd_err,
    output logic                      tccd_l_err,
    output logic                      tccd_s_err,
    output logic [15:0]               err_count
`ifdef DDR4_READ_LATENCY_CHECK_EN
    ,
    input  logic                      dq_valid,
    output logic                      tcl_err
`endif
);

    typedef enum logic [3:0] {
        CmdNone = 4'd0,
        CmdDes  = 4'd1,
        CmdNop  = 4'd2,
        CmdAct  = 4'd3,
        CmdMrs  = 4'd4,
        CmdRef  = 4'd5,
        CmdPre  = 4'd6,
        CmdPrea = 4'd7,
        CmdWr   = 4'd8,
        CmdWra  = 4'd9,
        CmdRd   = 4'd10,
        CmdRda  = 4'd11,
        CmdRsvd = 4'd12
    } cmd_e;

    // Timing limits above 255 cannot be reached by the saturating counters anyway.
    localparam logic [7:0] Trcd  = 8'(TRCD);
    localparam logic [7:0] TccdL = 8'(TCCD_L);
    localparam logic [7:0] TccdS = 8'(TCCD_S);

    cmd_e               cmd_d;
    logic               is_act, is_rw;
    logic [7:0]         trcd_cnt_q, tccd_cnt_q;
    logic               act_seen_q, rw_seen_q;
    logic [BG_BITS-1:0] bg_prev_q;
    logic               trcd_err_d, tccd_l_err_d, tccd_s_err_d;
    logic [16:0]        err_sum;
    logic [15:0]        err_count_d;
    logic               unused_pins;

    assign unused_pins = ^pin_A[AWIDTH-1:17];

    always_comb begin
        cmd_d = CmdNone;
        if (cke != 1'b1) begin
            cmd_d = CmdNone;
        end else if (cs_n) begin
            cmd_d = CmdDes;
        end else if (!act_n) begin
            cmd_d = CmdAct;
        end else begin
            case (pin_A[16:14])
                3'b000:  cmd_d = CmdMrs;
                3'b001:  cmd_d = CmdRef;
                3'b010:  cmd_d = pin_A[10] ? CmdPrea : CmdPre;
                3'b100:  cmd_d = pin_A[10] ? CmdWra : CmdWr;
                3'b101:  cmd_d = pin_A[10] ? CmdRda : CmdRd;
                3'b111:  cmd_d = CmdNop;
                default: cmd_d = CmdRsvd;
            endcase
        end
    end

    assign is_act = (cmd_d == CmdAct);
    assign is_rw  = (cmd_d == CmdWr) || (cmd_d == CmdWra) || (cmd_d == CmdRd) || (cmd_d == CmdRda);

    // Counters hold the distance to the last event at the moment of the current edge.
    assign trcd_err_d   = is_rw && act_seen_q && (trcd_cnt_q < Trcd);
    assign tccd_l_err_d = is_rw && rw_seen_q && (bg == bg_prev_q) && (tccd_cnt_q < TccdL);
    assign tccd_s_err_d = is_rw && rw_seen_q && (bg != bg_prev_q) && (tccd_cnt_q < TccdS);

`ifdef DDR4_READ_LATENCY_CHECK_EN
    logic [TCL-1:0] rd_pipe_q;
    logic           is_rd;
    logic           tcl_err_d;

    assign is_rd     = (cmd_d == CmdRd) || (cmd_d == CmdRda);
    assign tcl_err_d = rd_pipe_q[TCL-1] ^ dq_valid;
    assign err_sum   = {1'b0, err_count} + 17'(trcd_err_d) + 17'(tccd_l_err_d)
                     + 17'(tccd_s_err_d) + 17'(tcl_err_d);
`else
    assign err_sum   = {1'b0, err_count} + 17'(trcd_err_d) + 17'(tccd_l_err_d)
                     + 17'(tccd_s_err_d);
`endif

    assign err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    function automatic logic [7:0] inc_sat(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd        <= CmdNone;
            row_addr   <= '0;
            col_addr   <= '0;
            act_bank   <= '0;
            col_bank   <= '0;
            trcd_err   <= 1'b0;
            tccd_l_err <= 1'b0;
            tccd_s_err <= 1'b0;
            err_count  <= '0;
            trcd_cnt_q <= '0;
            tccd_cnt_q <= '0;
            act_seen_q <= 1'b0;
            rw_seen_q  <= 1'b0;
            bg_prev_q  <= '0;
`ifdef DDR4_READ_LATENCY_CHECK_EN
            rd_pipe_q  <= '0;
            tcl_err    <= 1'b0;
`endif
        end else begin
            cmd        <= cmd_d;
            trcd_err   <= trcd_err_d;
            tccd_l_err <= tccd_l_err_d;
            tccd_s_err <= tccd_s_err_d;
            err_count  <= err_count_d;
            trcd_cnt_q <= is_act ? 8'd1 : inc_sat(trcd_cnt_q);
            tccd_cnt_q <= is_rw ? 8'd1 : inc_sat(tccd_cnt_q);
            if (is_act) begin
                row_addr   <= pin_A[14:0];
                act_bank   <= {b, bg};
                act_seen_q <= 1'b1;
            end
            if (is_rw) begin
                col_addr  <= pin_A[9:0];
                col_bank  <= {b, bg};
                rw_seen_q <= 1'b1;
                bg_prev_q <= bg;
            end
`ifdef DDR4_READ_LATENCY_CHECK_EN
            rd_pipe_q  <= (rd_pipe_q << 1) | TCL'(is_rd);
            tcl_err    <= tcl_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ddr4_modport.sv
// Self-checking bench for ddr4_modport: directed scenarios plus random pin traffic,
// compared every cycle against an event-time reference model.
module tb_ddr4_modport;

    localparam int TRCD   = 16;
    localparam int TCCD_L = 6;
    localparam int TCCD_S = 4;
    localparam int TCL    = 16;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke     = 1'b0;
    logic        cs_n    = 1'b1;
    logic        act_n   = 1'b1;
    logic [17:0] pin_A   = '0;
    logic [1:0]  bg      = '0;
    logic [1:0]  b       = '0;
    logic [3:0]  cmd;
    logic [14:0] row_addr;
    logic [9:0]  col_addr;
    logic [3:0]  act_bank, col_bank;
    logic        trcd_err, tccd_l_err, tccd_s_err;
    logic [15:0] err_count;
`ifdef DDR4_READ_LATENCY_CHECK_EN
    logic        dq_valid = 1'b0;
    logic        tcl_err;
`endif

    always #5 clock = ~clock;

    ddr4_modport #(
        .AWIDTH (18),
        .BG_BITS(2),
        .B_BITS (2),
        .TRCD   (TRCD),
        .TCCD_L (TCCD_L),
        .TCCD_S (TCCD_S),
        .TCL    (TCL)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cke       (cke),
        .cs_n      (cs_n),
        .act_n     (act_n),
        .pin_A     (pin_A),
        .bg        (bg),
        .b         (b),
        .cmd       (cmd),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .act_bank  (act_bank),
        .col_bank  (col_bank),
        .trcd_err  (trcd_err),
        .tccd_l_err(tccd_l_err),
        .tccd_s_err(tccd_s_err),
        .err_count (err_count)
`ifdef DDR4_READ_LATENCY_CHECK_EN
        ,
        .dq_valid  (dq_valid),
        .tcl_err   (tcl_err)
`endif
    );

    // Reference model: remembers the cycle index of the last ACT / RD-WR and compares distances.
    int          cyc = 0;
    int          last_act = 0, last_rw = 0;
    bit          have_act = 0, have_rw = 0;
    logic [1:0]  last_bg = '0;
    int unsigned exp_cmd = 0, exp_cnt = 0;
    logic [14:0] exp_row = '0;
    logic [9:0]  exp_col = '0;
    logic [3:0]  exp_act_bank = '0, exp_col_bank = '0;
    bit          exp_trcd = 0, exp_l = 0, exp_s = 0, exp_tcl = 0;
    int          due_q[$];
    int unsigned op_code[8] = '{4, 5, 6, 12, 8, 10, 12, 2};

    int n_pass  = 0;
    int n_total = 0;

    task automatic model_clear();
        have_act = 0; have_rw = 0; last_bg = '0;
        exp_cmd = 0; exp_cnt = 0; exp_row = '0; exp_col = '0;
        exp_act_bank = '0; exp_col_bank = '0;
        exp_trcd = 0; exp_l = 0; exp_s = 0; exp_tcl = 0;
        due_q.delete();
    endtask

    task automatic model_step();
        int c;
        int op;
        int n;
        bit rw;
        bit due;
        if (cke !== 1'b1) c = 0;
        else if (cs_n) c = 1;
        else if (!act_n) c = 3;
        else begin
            op = int'(pin_A[16:14]);
            c  = int'(op_code[op]);
            if ((op == 2 || op == 4 || op == 5) && pin_A[10]) c = c + 1;
        end
        rw = (c >= 8 && c <= 11);
        exp_cmd = c;
        exp_trcd = 0; exp_l = 0; exp_s = 0; exp_tcl = 0;
        if (c == 3) begin
            have_act = 1; last_act = cyc;
            exp_row = pin_A[14:0]; exp_act_bank = {b, bg};
        end
        if (rw) begin
            exp_col = pin_A[9:0]; exp_col_bank = {b, bg};
            exp_trcd = have_act && (cyc - last_act < TRCD);
            if (have_rw) begin
                if (bg == last_bg) exp_l = (cyc - last_rw < TCCD_L);
                else exp_s = (cyc - last_rw < TCCD_S);
            end
            have_rw = 1; last_rw = cyc; last_bg = bg;
        end
        n = int'(exp_trcd) + int'(exp_l) + int'(exp_s);
        due = 0;
`ifdef DDR4_READ_LATENCY_CHECK_EN
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            due = 1;
            void'(due_q.pop_front());
        end
        exp_tcl = (due != dq_valid);
        if (c == 10 || c == 11) due_q.push_back(cyc + TCL);
        n = n + int'(exp_tcl);
`endif
        exp_cnt = (exp_cnt + n > 65535) ? 65535 : exp_cnt + n;
        cyc = cyc + 1 + int'(due & 1'b0);
    endtask

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) model_clear();
        else model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic compare_all();
        chk("cmd", 32'(cmd), 32'(exp_cmd));
        chk("row_addr", 32'(row_addr), 32'(exp_row));
        chk("col_addr", 32'(col_addr), 32'(exp_col));
        chk("act_bank", 32'(act_bank), 32'(exp_act_bank));
        chk("col_bank", 32'(col_bank), 32'(exp_col_bank));
        chk("trcd_err", 32'(trcd_err), 32'(exp_trcd));
        chk("tccd_l_err", 32'(tccd_l_err), 32'(exp_l));
        chk("tccd_s_err", 32'(tccd_s_err), 32'(exp_s));
        chk("err_count", 32'(err_count), 32'(exp_cnt));
`ifdef DDR4_READ_LATENCY_CHECK_EN
        chk("tcl_err", 32'(tcl_err), 32'(exp_tcl));
`endif
    endtask

    // Pins change on the falling edge; outputs are compared on the next falling edge.
    task automatic tick();
        @(negedge clock);
        compare_all();
    endtask

    task automatic drive(input logic k, input logic cs, input logic ac, input logic [17:0] a,
                         input logic [1:0] g, input logic [1:0] bb);
        cke = k; cs_n = cs; act_n = ac; pin_A = a; bg = g; b = bb;
        tick();
    endtask

    function automatic logic [17:0] mk_a(input logic [2:0] op, input logic ap,
                                         input logic [9:0] col);
        return {1'b0, op, 3'b000, ap, col};
    endfunction

    task automatic nop();
        drive(1'b1, 1'b0, 1'b1, mk_a(3'b111, 1'b0, 10'h0), 2'd0, 2'd0);
    endtask

    task automatic act(input logic [14:0] row, input logic [1:0] g, input logic [1:0] bb);
        drive(1'b1, 1'b0, 1'b0, {3'b000, row}, g, bb);
    endtask

    task automatic rd(input logic [9:0] col, input logic [1:0] g);
        drive(1'b1, 1'b0, 1'b1, mk_a(3'b101, 1'b0, col), g, 2'd0);
    endtask

    task automatic op_cmd(input logic [2:0] op, input logic ap);
        drive(1'b1, 1'b0, 1'b1, mk_a(op, ap, 10'h0), 2'd0, 2'd0);
    endtask

    initial begin
        int r;
        tick();
        tick();
        chk("lit_reset_cmd", 32'(cmd), 32'd0);
        chk("lit_reset_cnt", 32'(err_count), 32'd0);
        chk("lit_reset_row", 32'(row_addr), 32'd0);
        reset_n = 1'b1;

        act(15'h1234, 2'd1, 2'd2);
        chk("lit_act_cmd", 32'(cmd), 32'd3);
        chk("lit_act_row", 32'(row_addr), 32'h1234);
        chk("lit_act_bank", 32'(act_bank), 32'h9);
        chk("lit_act_err", 32'({trcd_err, tccd_l_err, tccd_s_err}), 32'd0);

        repeat (15) nop();
        rd(10'h2A, 2'd0);
        chk("lit_rd16_cmd", 32'(cmd), 32'd10);
        chk("lit_rd16_col", 32'(col_addr), 32'h2A);
        chk("lit_rd16_trcd", 32'(trcd_err), 32'd0);

        act(15'h0042, 2'd0, 2'd0);
        repeat (9) nop();
        rd(10'h2B, 2'd0);
        chk("lit_rd10_trcd", 32'(trcd_err), 32'd1);
        chk("lit_rd10_cnt", 32'(err_count), 32'd1);
        nop();
        chk("lit_trcd_pulse_end", 32'(trcd_err), 32'd0);

        act(15'h0007, 2'd0, 2'd1);
        repeat (16) nop();
        rd(10'h001, 2'd0);
        repeat (3) nop();
        rd(10'h002, 2'd0);
        chk("lit_tccd_l", 32'(tccd_l_err), 32'd1);
        repeat (3) nop();
        rd(10'h003, 2'd1);
        chk("lit_tccd_diff_ok", 32'({tccd_l_err, tccd_s_err}), 32'd0);
        repeat (2) nop();
        rd(10'h004, 2'd2);
        chk("lit_tccd_s", 32'(tccd_s_err), 32'd1);
`ifndef DDR4_READ_LATENCY_CHECK_EN
        chk("lit_tccd_cnt", 32'(err_count), 32'd3);
`endif

        drive(1'b1, 1'b1, 1'b0, 18'h3FFFF, 2'd0, 2'd0);
        chk("lit_des", 32'(cmd), 32'd1);
        op_cmd(3'b000, 1'b0);
        chk("lit_mrs", 32'(cmd), 32'd4);
        op_cmd(3'b001, 1'b0);
        chk("lit_ref", 32'(cmd), 32'd5);
        op_cmd(3'b010, 1'b1);
        chk("lit_prea", 32'(cmd), 32'd7);
        op_cmd(3'b100, 1'b1);
        chk("lit_wra", 32'(cmd), 32'd9);
        op_cmd(3'b111, 1'b0);
        chk("lit_nop", 32'(cmd), 32'd2);
        op_cmd(3'b011, 1'b0);
        chk("lit_rsvd", 32'(cmd), 32'd12);
        drive(1'b0, 1'b0, 1'b0, 18'h0, 2'd0, 2'd0);
        chk("lit_none", 32'(cmd), 32'd0);

        rd(10'h055, 2'd0);
        reset_n = 1'b0;
        tick();
        chk("lit_mid_reset_err", 32'({trcd_err, tccd_l_err, tccd_s_err}), 32'd0);
        chk("lit_mid_reset_cnt", 32'(err_count), 32'd0);
        reset_n = 1'b1;
        rd(10'h056, 2'd0);
        chk("lit_post_reset_cmd", 32'(cmd), 32'd10);
        chk("lit_post_reset_err", 32'({trcd_err, tccd_l_err, tccd_s_err}), 32'd0);

`ifdef DDR4_READ_LATENCY_CHECK_EN
        repeat (20) nop();
        rd(10'h010, 2'd0);
        repeat (15) nop();
        dq_valid = 1'b1;
        nop();
        dq_valid = 1'b0;
        chk("lit_tcl_on_time", 32'(tcl_err), 32'd0);
        rd(10'h011, 2'd1);
        repeat (14) nop();
        dq_valid = 1'b1;
        nop();
        dq_valid = 1'b0;
        chk("lit_tcl_early", 32'(tcl_err), 32'd1);
        nop();
        chk("lit_tcl_missing", 32'(tcl_err), 32'd1);
`endif

        repeat (1500) begin
            r = int'($urandom_range(0, 99));
`ifdef DDR4_READ_LATENCY_CHECK_EN
            dq_valid = ($urandom_range(0, 9) == 0);
`endif
            if (r < 8) begin
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 18'($urandom),
                      2'($urandom), 2'($urandom));
            end else if (r < 20) begin
                act(15'($urandom), 2'($urandom), 2'($urandom));
            end else if (r < 45) begin
                drive(1'b1, 1'b0, 1'b1,
                      mk_a(($urandom_range(0, 1) != 0) ? 3'b101 : 3'b100, 1'($urandom),
                           10'($urandom)),
                      2'($urandom), 2'($urandom));
            end else if (r < 47) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end else begin
                nop();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
